// File: rtl/bi_shift_pkg.sv
// Shared definitions for the bidirectional shift-register link (receive side).
package bi_shift_pkg;

   // Shift direction encoding carried on shift_dir
   localparam logic SHIFT_LEFT  = 1'b0;  // MSB first
   localparam logic SHIFT_RIGHT = 1'b1;  // LSB first

   // Receiver frame state
   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } rx_state_t;

endpackage

// File: rtl/sipo_shift_core.sv
// Serial-in shift register with bit counter; raises done combinationally on the
// bit that completes a word and exposes that completed word on word.
module sipo_shift_core
   import bi_shift_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bit_valid,
   input  logic             serial_in,
   input  logic             dir,
   input  logic             flush,
   output logic [WIDTH-1:0] word,
   output logic             done
);

   localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] sr_next;
   logic [CW-1:0]    count;
   logic             shift_en;

   // flush wins over a bit arriving in the same cycle
   assign shift_en = bit_valid & ~flush;
   assign done     = shift_en && (count == CW'(WIDTH - 1));
   assign word     = sr_next;

   // Next shift-register value for the selected direction
   always_comb begin
      sr_next = sr;
      if (dir == SHIFT_RIGHT)
         sr_next = {serial_in, sr[WIDTH-1:1]};
      else
         sr_next = {sr[WIDTH-2:0], serial_in};
   end

   // Shift register and bit counter; both restart after a completed word
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         sr    <= '0;
         count <= '0;
      end else if (shift_en) begin
         if (done) begin
            sr    <= '0;
            count <= '0;
         end else begin
            sr    <= sr_next;
            count <= count + CW'(1);
         end
      end
   end

endmodule

// File: rtl/bi_shift_deser.sv
// Receive end of the bidirectional shift link: serial-in / parallel-out
// deserializer with valid/ready output handshake and sticky overrun flag.
module bi_shift_deser
   import bi_shift_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             serial_in,
   input  logic             bit_valid,
   input  logic             shift_dir,
   input  logic             flush,
   input  logic             clr_ovr,
   input  logic             out_ready,
   output logic [WIDTH-1:0] data_out,
   output logic             out_valid,
   output logic             busy,
   output logic             overrun
);

   rx_state_t        state;
   logic             dir_q;
   logic             eff_dir;
   logic [WIDTH-1:0] word;
   logic             done;
   logic             can_load;

   // First bit of a frame uses the live direction; later bits use the latched one
   assign eff_dir  = (state == IDLE) ? shift_dir : dir_q;
   // Holding register is free if empty or being drained this cycle
   assign can_load = ~out_valid | out_ready;
   assign busy     = (state == RECV);

   sipo_shift_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk       (clk),
      .rst       (rst),
      .bit_valid (bit_valid),
      .serial_in (serial_in),
      .dir       (eff_dir),
      .flush     (flush),
      .word      (word),
      .done      (done)
   );

   // Frame FSM, output holding register, handshake and overrun flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         dir_q     <= SHIFT_LEFT;
         data_out  <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (flush) begin
            state <= IDLE;
         end else if (bit_valid) begin
            case (state)
               IDLE: begin
                  dir_q <= shift_dir;
                  state <= RECV;
               end
               RECV: begin
                  if (done)
                     state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end

         if (done && can_load) begin
            data_out  <= word;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         // A new overrun takes precedence over a clear in the same cycle
         if (done && !can_load)
            overrun <= 1'b1;
         else if (clr_ovr)
            overrun <= 1'b0;
      end
   end

endmodule
